// File: rtl/mem_pkg.sv
// Shared definitions for the MIPS memory-access stage: access sizes, FSM states
// and the width of the access timeout counter.
package mem_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE     = 2'b00,
      SZ_HALF     = 2'b01,
      SZ_WORD     = 2'b10,
      SZ_WORD_ALT = 2'b11
   } mem_size_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } mem_state_e;

   // Wide enough for TIMEOUT_CYCLES up to 255.
   localparam int unsigned TO_CNT_W = 8;

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering for data-memory accesses: store replication and byte
// enables, plus load lane extraction with sign/zero extension.
module mem_align
   import mem_pkg::*;
(
   input  logic [1:0]  lane,
   input  mem_size_e   size,
   input  logic        sext,
   input  logic        write,
   input  logic [31:0] store_data,
   input  logic [31:0] load_word,
   output logic [3:0]  be,
   output logic [31:0] lane_data,
   output logic [31:0] load_data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      case (lane)
         2'd0:    byte_sel = load_word[7:0];
         2'd1:    byte_sel = load_word[15:8];
         2'd2:    byte_sel = load_word[23:16];
         default: byte_sel = load_word[31:24];
      endcase
      half_sel = lane[1] ? load_word[31:16] : load_word[15:0];
   end

   always_comb begin
      be        = 4'b1111;
      lane_data = store_data;
      load_data = load_word;
      case (size)
         SZ_BYTE: begin
            be        = 4'b0001 << lane;
            lane_data = {4{store_data[7:0]}};
            load_data = {{24{sext & byte_sel[7]}}, byte_sel};
         end
         SZ_HALF: begin
            be        = lane[1] ? 4'b1100 : 4'b0011;
            lane_data = {2{store_data[15:0]}};
            load_data = {{16{sext & half_sel[15]}}, half_sel};
         end
         default: ;
      endcase
      // Reads always fetch the whole word.
      if (!write) be = 4'b1111;
   end

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: data-memory req/ack port, lane steering, stall generation and
// the MEM/WB register. Define MEM_SUBWORD_EN to enable byte/halfword accesses.
module mem_stage
   import mem_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 16
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        EXtoMEM_valid,
   input  logic [31:0] EXtoMEM_ALU_result,
   input  logic [31:0] EXtoMEM_WriteData,
   input  logic [4:0]  EXtoMEM_RegDest,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [1:0]  MemSize,
   input  logic        MemSigned,
   input  logic        MemtoReg,
   input  logic        RegWrite,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        mem_stall,
   output logic        MEMtoWB_valid,
   output logic        MEMtoWB_RegWrite,
   output logic        MEMtoWB_MemtoReg,
   output logic [31:0] MEMtoWB_ReadData,
   output logic [31:0] MEMtoWB_ALU_result,
   output logic [4:0]  MEMtoWB_RegDest,
   output logic        MEMtoWB_misalign,
   output logic        MEMtoWB_buserr
);

   mem_state_e          state, state_nx;
   logic [TO_CNT_W-1:0] cnt, cnt_nx;
   mem_size_e           size;
   logic                sext;
   logic                mem_op, is_load, misalign, go, timeout;
   logic                acked, abort;
   logic [31:0]         load_data;

`ifdef MEM_SUBWORD_EN
   assign size = mem_size_e'(MemSize);
   assign sext = MemSigned;
`else
   logic unused_cfg;
   assign unused_cfg = ^{MemSize, MemSigned};
   assign size       = SZ_WORD;
   assign sext       = 1'b0;
`endif

   assign mem_op  = EXtoMEM_valid & (MemRead | MemWrite);
   assign is_load = MemRead & ~MemWrite;
   assign go      = mem_op & ~misalign;
   assign timeout = (state == ST_WAIT) & (cnt == TO_CNT_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      case (size)
         SZ_BYTE: misalign = 1'b0;
         SZ_HALF: misalign = EXtoMEM_ALU_result[0];
         default: misalign = |EXtoMEM_ALU_result[1:0];
      endcase
   end

   mem_align u_align (
      .lane       (EXtoMEM_ALU_result[1:0]),
      .size       (size),
      .sext       (sext),
      .write      (MemWrite),
      .store_data (EXtoMEM_WriteData),
      .load_word  (dmem_rdata),
      .be         (dmem_be),
      .lane_data  (dmem_wdata),
      .load_data  (load_data)
   );

   assign dmem_addr = {EXtoMEM_ALU_result[31:2], 2'b00};
   assign dmem_we   = dmem_req & MemWrite;

   // Request is dropped in the timeout cycle, but an ack landing there still wins.
   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      dmem_req  = 1'b0;
      mem_stall = 1'b0;
      acked     = 1'b0;
      abort     = 1'b0;
      if (!rst) begin
         case (state)
            ST_IDLE: begin
               if (go) begin
                  dmem_req = 1'b1;
                  if (dmem_ack) begin
                     acked = 1'b1;
                  end else begin
                     mem_stall = 1'b1;
                     state_nx  = ST_WAIT;
                     cnt_nx    = '0;
                  end
               end
            end
            ST_WAIT: begin
               dmem_req = ~timeout;
               if (dmem_ack) begin
                  acked    = 1'b1;
                  state_nx = ST_IDLE;
               end else if (timeout) begin
                  abort    = 1'b1;
                  state_nx = ST_IDLE;
               end else begin
                  mem_stall = 1'b1;
                  cnt_nx    = cnt + 1'b1;
               end
            end
            default: state_nx = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state              <= ST_IDLE;
         cnt                <= '0;
         MEMtoWB_valid      <= 1'b0;
         MEMtoWB_RegWrite   <= 1'b0;
         MEMtoWB_MemtoReg   <= 1'b0;
         MEMtoWB_ReadData   <= '0;
         MEMtoWB_ALU_result <= '0;
         MEMtoWB_RegDest    <= '0;
         MEMtoWB_misalign   <= 1'b0;
         MEMtoWB_buserr     <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         if (mem_stall) begin
            MEMtoWB_valid      <= 1'b0;
            MEMtoWB_RegWrite   <= 1'b0;
            MEMtoWB_MemtoReg   <= 1'b0;
            MEMtoWB_ReadData   <= '0;
            MEMtoWB_ALU_result <= '0;
            MEMtoWB_RegDest    <= '0;
            MEMtoWB_misalign   <= 1'b0;
            MEMtoWB_buserr     <= 1'b0;
         end else begin
            MEMtoWB_valid      <= EXtoMEM_valid;
            MEMtoWB_RegWrite   <= RegWrite & EXtoMEM_valid & ~(mem_op & misalign) & ~abort;
            MEMtoWB_MemtoReg   <= MemtoReg;
            MEMtoWB_ReadData   <= (acked & is_load) ? load_data : '0;
            MEMtoWB_ALU_result <= EXtoMEM_ALU_result;
            MEMtoWB_RegDest    <= EXtoMEM_RegDest;
            MEMtoWB_misalign   <= mem_op & misalign;
            MEMtoWB_buserr     <= abort;
         end
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized self-checking bench for mem_stage against a transaction-level model;
// honours MEM_SUBWORD_EN in the same way as the design.
module tb_mem_stage;

   localparam int unsigned T = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        EXtoMEM_valid;
   logic [31:0] EXtoMEM_ALU_result;
   logic [31:0] EXtoMEM_WriteData;
   logic [4:0]  EXtoMEM_RegDest;
   logic        MemRead, MemWrite;
   logic [1:0]  MemSize;
   logic        MemSigned, MemtoReg, RegWrite;
   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;
   logic        mem_stall;
   logic        MEMtoWB_valid, MEMtoWB_RegWrite, MEMtoWB_MemtoReg;
   logic [31:0] MEMtoWB_ReadData, MEMtoWB_ALU_result;
   logic [4:0]  MEMtoWB_RegDest;
   logic        MEMtoWB_misalign, MEMtoWB_buserr;

   int unsigned n_chk = 0;
   int unsigned n_err = 0;

   always #5 clk = ~clk;

   mem_stage #(.TIMEOUT_CYCLES(T)) dut (
      .clk                (clk),
      .rst                (rst),
      .EXtoMEM_valid      (EXtoMEM_valid),
      .EXtoMEM_ALU_result (EXtoMEM_ALU_result),
      .EXtoMEM_WriteData  (EXtoMEM_WriteData),
      .EXtoMEM_RegDest    (EXtoMEM_RegDest),
      .MemRead            (MemRead),
      .MemWrite           (MemWrite),
      .MemSize            (MemSize),
      .MemSigned          (MemSigned),
      .MemtoReg           (MemtoReg),
      .RegWrite           (RegWrite),
      .dmem_req           (dmem_req),
      .dmem_we            (dmem_we),
      .dmem_addr          (dmem_addr),
      .dmem_be            (dmem_be),
      .dmem_wdata         (dmem_wdata),
      .dmem_ack           (dmem_ack),
      .dmem_rdata         (dmem_rdata),
      .mem_stall          (mem_stall),
      .MEMtoWB_valid      (MEMtoWB_valid),
      .MEMtoWB_RegWrite   (MEMtoWB_RegWrite),
      .MEMtoWB_MemtoReg   (MEMtoWB_MemtoReg),
      .MEMtoWB_ReadData   (MEMtoWB_ReadData),
      .MEMtoWB_ALU_result (MEMtoWB_ALU_result),
      .MEMtoWB_RegDest    (MEMtoWB_RegDest),
      .MEMtoWB_misalign   (MEMtoWB_misalign),
      .MEMtoWB_buserr     (MEMtoWB_buserr)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Access size in bytes after configuration: 1, 2 or 4.
   function automatic int unsigned eff_bytes(input logic [1:0] sz);
`ifdef MEM_SUBWORD_EN
      if (sz == 2'd0) return 1;
      if (sz == 2'd1) return 2;
      return 4;
`else
      return 4;
`endif
   endfunction

   function automatic logic [3:0] exp_be(input int unsigned nb, input logic [31:0] a, input logic st);
      logic [3:0] b;
      if (!st || nb == 4) return 4'hF;
      b = (nb == 1) ? 4'h1 : 4'h3;
      return b << (a % 4);
   endfunction

   function automatic logic [31:0] exp_wdata(input int unsigned nb, input logic [31:0] d);
      if (nb == 1) return (d & 32'hFF) * 32'h01010101;
      if (nb == 2) return (d & 32'hFFFF) * 32'h00010001;
      return d;
   endfunction

   function automatic logic [31:0] exp_load(input int unsigned nb, input logic sg,
                                           input logic [31:0] a, input logic [31:0] w);
      logic [31:0] v;
      if (nb == 4) return w;
      if (nb == 1) begin
         v = (w >> (8 * (a % 4))) & 32'hFF;
         if (sg && v >= 32'h80) v = v + 32'hFFFFFF00;
      end else begin
         v = (w >> (8 * (a % 4))) & 32'hFFFF;
         if (sg && v >= 32'h8000) v = v + 32'hFFFF0000;
      end
      return v;
   endfunction

   // One instruction through MEM; ack arrives in request cycle wait_n (> T means never).
   // Called and returns at posedge+1.
   task automatic run(input logic v, input logic rd, input logic wr, input logic [1:0] sz,
                      input logic sg, input logic mtr, input logic rw, input logic [4:0] dest,
                      input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdat,
                      input int unsigned wait_n);
      int unsigned nb, stalls;
      logic memop, st, ld, mis, go, abort;
      nb     = eff_bytes(sz);
      memop  = v && (rd || wr);
      st     = wr;
      ld     = rd && !wr;
      mis    = (addr % nb) != 0;
      go     = memop && !mis;
      abort  = go && (wait_n > T);
      stalls = !go ? 0 : (wait_n <= T ? wait_n : T);

      EXtoMEM_valid      = v;
      MemRead            = rd;
      MemWrite           = wr;
      MemSize            = sz;
      MemSigned          = sg;
      MemtoReg           = mtr;
      RegWrite           = rw;
      EXtoMEM_RegDest    = dest;
      EXtoMEM_ALU_result = addr;
      EXtoMEM_WriteData  = wd;
      dmem_rdata         = rdat;

      for (int unsigned i = 0; i <= stalls; i++) begin
         dmem_ack = go ? (i == wait_n) : 1'($urandom_range(0, 1));
         #1;
         check("stall", mem_stall, i < stalls);
         check("req", dmem_req, go && (i < T));
         if (go && i == 0) begin
            check("we", dmem_we, st);
            check("addr", dmem_addr, addr & 32'hFFFFFFFC);
            check("be", dmem_be, exp_be(nb, addr, st));
            if (st) check("wdata", dmem_wdata, exp_wdata(nb, wd));
         end
         @(posedge clk);
         #1;
         if (i < stalls) check("bubble", MEMtoWB_valid, 1'b0);
      end
      dmem_ack = 1'b0;

      check("wb_valid", MEMtoWB_valid, v);
      check("wb_misalign", MEMtoWB_misalign, memop && mis);
      check("wb_buserr", MEMtoWB_buserr, abort);
      check("wb_rdata", MEMtoWB_ReadData, (go && !abort && ld) ? exp_load(nb, sg, addr, rdat) : 32'h0);
      if (v) begin
         check("wb_regwrite", MEMtoWB_RegWrite, rw && !(memop && mis) && !abort);
         check("wb_memtoreg", MEMtoWB_MemtoReg, mtr);
         check("wb_dest", MEMtoWB_RegDest, dest);
         check("wb_alu", MEMtoWB_ALU_result, addr);
      end
   endtask

   initial begin
      rst = 1'b1;
      EXtoMEM_valid = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; MemSize = 2'd2;
      MemSigned = 1'b0; MemtoReg = 1'b0; RegWrite = 1'b1; EXtoMEM_RegDest = 5'd3;
      EXtoMEM_ALU_result = 32'h100; EXtoMEM_WriteData = '0; dmem_ack = 1'b0; dmem_rdata = '0;
      #3;
      check("rst_req", dmem_req, 1'b0);
      check("rst_we", dmem_we, 1'b0);
      check("rst_stall", mem_stall, 1'b0);
      check("rst_valid", MEMtoWB_valid, 1'b0);
      check("rst_rdata", MEMtoWB_ReadData, 32'h0);
      @(posedge clk);
      #1;
      EXtoMEM_valid = 1'b0;
      rst = 1'b0;

      // ALU op, then the plain word load with three wait cycles.
      run(1, 0, 0, 2'd2, 0, 1, 1, 5'd5, 32'h1234, 32'h0, 32'h0, 0);
      check("alu_passthru", MEMtoWB_ALU_result, 32'h1234);
      run(1, 1, 0, 2'd2, 0, 0, 1, 5'd8, 32'h100, 32'h0, 32'hDEADBEEF, 3);
      check("lw_wait3", MEMtoWB_ReadData, 32'hDEADBEEF);
      run(1, 1, 0, 2'd0, 1, 0, 1, 5'd9, 32'h103, 32'h0, 32'h80FFFFFF, 0);
      run(1, 1, 0, 2'd0, 0, 0, 1, 5'd9, 32'h103, 32'h0, 32'h80FFFFFF, 0);
      run(1, 0, 1, 2'd1, 0, 0, 0, 5'd0, 32'h202, 32'h0000ABCD, 32'h0, 0);
      run(1, 1, 0, 2'd2, 0, 0, 1, 5'd4, 32'h101, 32'h0, 32'h0, 0);
      run(1, 0, 1, 2'd2, 0, 0, 0, 5'd0, 32'h300, 32'h11223344, 32'h0, T + 1);
      run(1, 1, 0, 2'd2, 0, 0, 1, 5'd7, 32'h304, 32'h0, 32'hCAFEF00D, T);
      run(1, 1, 1, 2'd2, 0, 0, 0, 5'd2, 32'h308, 32'h55AA55AA, 32'h0, 1);
      run(0, 1, 0, 2'd2, 0, 0, 1, 5'd6, 32'h30C, 32'h0, 32'h0, 0);

      // Reset arriving mid-WAIT must drop the request at once and retire nothing.
      EXtoMEM_valid = 1'b1; MemRead = 1'b0; MemWrite = 1'b1; MemSize = 2'd2;
      RegWrite = 1'b0; EXtoMEM_ALU_result = 32'h400; dmem_ack = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2;
      check("wait_req", dmem_req, 1'b1);
      rst = 1'b1;
      #1;
      check("midrst_req", dmem_req, 1'b0);
      check("midrst_stall", mem_stall, 1'b0);
      check("midrst_valid", MEMtoWB_valid, 1'b0);
      check("midrst_buserr", MEMtoWB_buserr, 1'b0);
      @(posedge clk);
      #1;
      EXtoMEM_valid = 1'b0;
      rst = 1'b0;
      run(1, 0, 1, 2'd2, 0, 0, 0, 5'd0, 32'h404, 32'h0BADF00D, 32'h0, T + 1);

      for (int unsigned k = 0; k < 300; k++) begin
         logic [31:0] a;
         logic [1:0]  op;
         a  = $urandom;
         if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
         op = 2'($urandom_range(0, 3));
         run(($urandom % 10) != 0, op[0], op[1], 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             5'($urandom), a, $urandom, $urandom, $urandom_range(0, T + 1));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
